// File: rtl/tt_bist_engine.sv
// Logic BIST engine: drives LFSR stimulus vectors into a block under test and
// compacts the latency-aligned responses into a 32-bit MISR signature.
module tt_bist_engine #(
    parameter int          CH    = 1,
    parameter int          LEN_W = 16,
    parameter int          LAT   = 1,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] run_len,
    input  logic [31:0]      exp_sig,
    input  logic [8*CH-1:0]  resp_in,
    output logic [8*CH-1:0]  stim_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      signature
);

    localparam int SW = 8 * CH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_nxt;
    logic [31:0]      misr;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [2:0]       dcnt;
    logic             stim_valid;
    logic             cap_valid;
    logic             accept;

    // Galois LFSR/MISR step, polynomial x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    assign lfsr_nxt   = step(lfsr);
    assign stim_valid = (state == RUN);
    assign accept     = ena && start && !abort && (state == IDLE || state == DONE);

    // Control FSM. stim_out is loaded one edge ahead so it always shows the
    // vector currently held in lfsr while in RUN, and zero everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            cnt      <= '0;
            len_q    <= '0;
            dcnt     <= '0;
            stim_out <= '0;
        end else if (ena) begin
            if (abort) begin
                state    <= IDLE;
                stim_out <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (accept) begin
                            len_q <= run_len;
                            lfsr  <= SEED;
                            cnt   <= '0;
                            if (run_len == '0) begin
                                state    <= DONE;
                                stim_out <= '0;
                            end else begin
                                state    <= RUN;
                                stim_out <= SEED[SW-1:0];
                            end
                        end
                    end
                    RUN: begin
                        lfsr <= lfsr_nxt;
                        cnt  <= cnt + LEN_W'(1);
                        // Compare against len-1 so a full-scale run never wraps cnt.
                        if (cnt == len_q - LEN_W'(1)) begin
                            stim_out <= '0;
                            dcnt     <= '0;
                            state    <= (LAT == 0) ? DONE : DRAIN;
                        end else begin
                            stim_out <= lfsr_nxt[SW-1:0];
                        end
                    end
                    DRAIN: begin
                        dcnt <= dcnt + 3'd1;
                        if (dcnt == 3'(LAT - 1)) begin
                            state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Valid pipeline marks which cycles carry the response to a driven vector.
    generate
        if (LAT == 0) begin : g_lat0
            assign cap_valid = stim_valid;
        end else begin : g_latn
            logic [LAT-1:0] vpipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vpipe <= '0;
                end else if (ena) begin
                    if (abort) begin
                        vpipe <= '0;
                    end else begin
                        vpipe <= (vpipe << 1) | LAT'(stim_valid);
                    end
                end
            end
            assign cap_valid = vpipe[LAT-1];
        end
    endgenerate

    // NOTE: capture is also gated by !abort so an aborted run leaves the
    // signature exactly as it stood before the abort cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr <= '0;
        end else if (ena && !abort) begin
            if (accept) begin
                misr <= '0;
            end else if (cap_valid) begin
                misr <= step(misr) ^ 32'(resp_in);
            end
        end
    end

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign pass      = done && (misr == exp_sig);
    assign signature = misr;

endmodule
